// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back mux, 32x32 GPR file, forwarding export, retire counter (option: WB_BYPASS_EN)
module wb_regfile #(
   parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
   parameter logic [31:0] GP_INIT = 32'h0000_1800,
   parameter int          CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      IMemData,
   input  logic [31:0]      IALUOut,
   input  logic [31:0]      IPCPlus4,
   input  logic [4:0]       IWriteReg,
   input  logic             ICRegWrite,
   input  logic [1:0]       ICMemtoReg,
   input  logic [4:0]       IReadReg1,
   input  logic [4:0]       IReadReg2,
   output logic [31:0]      OReadData1,
   output logic [31:0]      OReadData2,
   output logic [31:0]      OWBData,
   output logic [4:0]       OWBWriteReg,
   output logic             OWBRegWrite,
   output logic [CNT_W-1:0] ORetireCount
);

   logic [31:0]      regs [0:31];
   logic [CNT_W-1:0] retire_cnt;

   // r0 writes never count as a commit and are never forwarded
   assign OWBRegWrite  = ICRegWrite && (IWriteReg != 5'd0);
   assign OWBWriteReg  = IWriteReg;
   assign ORetireCount = retire_cnt;

   // write-back source select; the reserved encoding falls back to the ALU result
   always_comb begin
      OWBData = IALUOut;
      case (ICMemtoReg)
         2'b01:   OWBData = IMemData;
         2'b10:   OWBData = IPCPlus4;
         default: OWBData = IALUOut;
      endcase
   end

   // read port A: r0 forced to zero, optional write-first bypass
   always_comb begin
      OReadData1 = (IReadReg1 == 5'd0) ? 32'd0 : regs[IReadReg1];
`ifdef WB_BYPASS_EN
      if (OWBRegWrite && (IReadReg1 == IWriteReg))
         OReadData1 = OWBData;
`endif
   end

   // read port B: resolved independently of port A
   always_comb begin
      OReadData2 = (IReadReg2 == 5'd0) ? 32'd0 : regs[IReadReg2];
`ifdef WB_BYPASS_EN
      if (OWBRegWrite && (IReadReg2 == IWriteReg))
         OReadData2 = OWBData;
`endif
   end

   // register array and retire counter; reset discards any write in the same cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            if (i == 28)
               regs[i[4:0]] <= GP_INIT;
            else if (i == 29)
               regs[i[4:0]] <= SP_INIT;
            else
               regs[i[4:0]] <= 32'd0;
         end
         retire_cnt <= '0;
      end else if (OWBRegWrite) begin
         regs[IWriteReg] <= OWBData;
         retire_cnt      <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
